s2p_lanes: RTL

- Parametrised serial-to-parallel deserialiser. Successor to the fixed 64-bit, single-lane s2p.
- Assembles DATA_W-bit words from LANES serial bits per enabled cycle, with selectable bit order and frame resynchronisation.
- Presents each completed word on a valid/ready output holding register, with overrun detection.
- Sits between a serial link front-end and word-wide downstream logic.

---
 rtl/s2p_pkg.sv | 22 ++
 rtl/s2p_lanes_if.sv | 32 +++
 rtl/s2p_lanes_shift.sv | 73 +++++++
 rtl/s2p_lanes.sv | 72 +++++++
 4 files changed

// File: rtl/s2p_pkg.sv
// s2p_pkg: shared constants and helpers for the s2p_lanes deserialiser.
//   S2P_MSB_FIRST / S2P_LSB_FIRST : bit-order selector values for MSB_FIRST
//   beats(data_w, lanes)          : beats needed to assemble one word
//   cnt_w(n_beats)                : beat counter width, never less than 1
package s2p_pkg;

    localparam int S2P_MSB_FIRST = 1;
    localparam int S2P_LSB_FIRST = 0;

    function automatic int beats(input int data_w, input int lanes);
        // Guard against a zero lane count so the elaboration check in the
        // top level reports the problem instead of a divide-by-zero.
        return (lanes < 1) ? 1 : data_w / lanes;
    endfunction

    function automatic int cnt_w(input int n_beats);
        int w;
        w = $clog2(n_beats);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/s2p_lanes_if.sv
// s2p_lanes_if: serial input side and word output side of s2p_lanes.
//   enable, serial_in, frame_start : serial beat from the link front-end
//   data_out, data_valid, data_ready : word holding register handshake
//   overrun : one-cycle pulse when a completed word had to be dropped
//   busy    : a partial word is in progress
//   master  : the side driving serial beats and consuming words
//   slave   : the deserialiser
interface s2p_lanes_if #(
    parameter int DATA_W = 64,
    parameter int LANES  = 1
);

    logic              enable;
    logic [LANES-1:0]  serial_in;
    logic              frame_start;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              overrun;
    logic              busy;

    modport master (
        output enable, serial_in, frame_start, data_ready,
        input  data_out, data_valid, overrun, busy
    );

    modport slave (
        input  enable, serial_in, frame_start, data_ready,
        output data_out, data_valid, overrun, busy
    );

endinterface

// File: rtl/s2p_lanes_shift.sv
// s2p_lanes_shift: shift register plus beat counter.
//   clk, rst     : clock, synchronous active-high reset
//   enable       : beat qualifier
//   frame_start  : current cycle is beat 0 of a new word
//   serial_in    : LANES bits of the current beat
//   word         : word as it will stand after this edge (valid with word_done)
//   word_done    : combinational strobe, this edge samples the last beat
//   busy         : beat count is non-zero
module s2p_lanes_shift
    import s2p_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = S2P_MSB_FIRST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              frame_start,
    input  logic [LANES-1:0]  serial_in,
    output logic [DATA_W-1:0] word,
    output logic              word_done,
    output logic              busy
);

    localparam int             BEATS = beats(DATA_W, LANES);
    localparam int             CW    = cnt_w(BEATS);
    localparam logic [CW-1:0]  LAST  = CW'(BEATS - 1);

    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic [CW-1:0]     base;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] sr_next;

    // Stale bits left by a discarded partial word are shifted out before
    // the next completion, so frame_start only has to restart the count.
    always_comb begin
        base      = frame_start ? '0 : cnt;
        sr_next   = sr;
        cnt_next  = cnt;
        word_done = 1'b0;
        if (enable) begin
            if (MSB_FIRST == S2P_MSB_FIRST) begin
                sr_next = (sr << LANES) | DATA_W'(serial_in);
            end else begin
                sr_next = (sr >> LANES) | (DATA_W'(serial_in) << (DATA_W - LANES));
            end
            if (base == LAST) begin
                cnt_next  = '0;
                word_done = 1'b1;
            end else begin
                cnt_next = base + 1'b1;
            end
        end else if (frame_start) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            sr  <= sr_next;
            cnt <= cnt_next;
        end
    end

    assign word = sr_next;
    assign busy = (cnt != '0);

endmodule

// File: rtl/s2p_lanes.sv
// s2p_lanes: parametrised serial-to-parallel deserialiser.
//   clk, rst : clock, synchronous active-high reset
//   bus      : s2p_lanes_if slave (serial beats in, word handshake out)
// Completed words load a valid/ready holding register; a completion while
// the register is full and not being consumed is dropped with overrun.
module s2p_lanes
    import s2p_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = S2P_MSB_FIRST
) (
    input  logic         clk,
    input  logic         rst,
    s2p_lanes_if.slave   bus
);

    if (LANES < 1) begin : g_bad_lanes
        $fatal(1, "s2p_lanes: LANES must be at least 1");
    end else if (DATA_W % LANES != 0) begin : g_bad_width
        $fatal(1, "s2p_lanes: DATA_W must be a multiple of LANES");
    end

    logic [DATA_W-1:0] word;
    logic              word_done;
    logic              shift_busy;
    logic [DATA_W-1:0] hold_data;
    logic              hold_valid;
    logic              overrun_q;

    s2p_lanes_shift #(
        .DATA_W    (DATA_W),
        .LANES     (LANES),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk         (clk),
        .rst         (rst),
        .enable      (bus.enable),
        .frame_start (bus.frame_start),
        .serial_in   (bus.serial_in),
        .word        (word),
        .word_done   (word_done),
        .busy        (shift_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (hold_valid && bus.data_ready) begin
                hold_valid <= 1'b0;
            end
            if (word_done) begin
                if (!hold_valid || bus.data_ready) begin
                    hold_data  <= word;
                    hold_valid <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign bus.data_out   = hold_data;
    assign bus.data_valid = hold_valid;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = shift_busy;

endmodule
